// File: rtl/pc_gen.sv
// Fetch-PC generator: owns the fetch PC, issues block requests, hands completed
// blocks to the ibuffer and arbitrates redirect/interrupt/predict targets.
module pc_gen #(
  parameter int ADDR_W      = 48,
  parameter int FETCH_BYTES = 64,
  parameter int INST_BYTES  = 4,
  parameter int INDEX_LO    = 3,
  parameter int INDEX_W     = 19,
  parameter int CNT_W       = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [ADDR_W-1:0]  i_boot_addr,
  input  logic               i_redirect_valid,
  input  logic [ADDR_W-1:0]  i_redirect_target,
  input  logic               i_interrupt_valid,
  input  logic [ADDR_W-1:0]  i_interrupt_addr,
  input  logic               i_predict_valid,
  input  logic [ADDR_W-1:0]  i_predict_target,
  output logic               o_req_valid,
  output logic [INDEX_W-1:0] o_req_index,
  input  logic               i_req_ready,
  input  logic               i_resp_done,
  output logic               o_fetch_valid,
  output logic [ADDR_W-1:0]  o_fetch_pc,
  input  logic               i_fetch_ack,
  output logic               o_clear_ibuffer,
  output logic               o_cancel_fetch,
  output logic [CNT_W-1:0]   o_redirect_count
);

  localparam logic [ADDR_W-1:0] INST_MASK  = ~ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] FETCH_MASK = ~ADDR_W'(FETCH_BYTES - 1);
  localparam logic [ADDR_W-1:0] FETCH_INC  = ADDR_W'(FETCH_BYTES);

  typedef enum logic [2:0] {
    S_BOOT, S_REQ, S_WAIT, S_DRAIN, S_DELIVER, S_NEXT, S_APPLY
  } state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic                r_redir_pend, r_pred_pend;
  logic [ADDR_W-1:0]   r_redir_tgt, r_pred_tgt;

  logic                w_redir_live, w_redir_any, w_pred_any, w_pred_block;
  logic [ADDR_W-1:0]   w_redir_tgt, w_pred_tgt, w_seq_pc;
  logic                w_apply, w_clr_late, w_pred_use;

  // Live inputs take precedence over the latches; redirect beats interrupt.
  assign w_redir_live = i_redirect_valid | i_interrupt_valid;
  assign w_redir_any  = w_redir_live | r_redir_pend;
  assign w_redir_tgt  = (i_redirect_valid  ? i_redirect_target :
                         i_interrupt_valid ? i_interrupt_addr  : r_redir_tgt) & INST_MASK;
  assign w_pred_any   = i_predict_valid | r_pred_pend;
  assign w_pred_tgt   = (i_predict_valid ? i_predict_target : r_pred_tgt) & INST_MASK;
  assign w_pred_block = w_redir_any | (r_state == S_DRAIN) | (r_state == S_APPLY);
  assign w_seq_pc     = (r_pc & FETCH_MASK) + FETCH_INC;
  assign o_req_index  = r_pc[INDEX_LO +: INDEX_W];

  always_comb begin
    w_next     = r_state;
    w_pc_nxt   = r_pc;
    w_apply    = 1'b0;
    w_clr_late = 1'b0;
    w_pred_use = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_pc_nxt = i_boot_addr & INST_MASK;
        w_next   = S_REQ;
      end
      S_REQ: begin
        if (i_req_ready) begin
          w_next = w_redir_any ? S_DRAIN : S_WAIT;
        end else if (w_redir_any) begin
          // Not yet accepted: retarget in place, arbiter only samples on ready.
          w_pc_nxt   = w_redir_tgt;
          w_apply    = 1'b1;
          w_clr_late = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_resp_done) w_next = w_redir_any ? S_APPLY : S_DELIVER;
        else if (w_redir_any) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (i_resp_done) w_next = S_APPLY;
      end
      S_DELIVER: begin
        if (w_redir_any) w_next = S_APPLY;
        else if (i_fetch_ack) w_next = S_NEXT;
      end
      S_NEXT: begin
        w_next = S_REQ;
        if (w_redir_any) begin
          w_pc_nxt   = w_redir_tgt;
          w_apply    = 1'b1;
          w_clr_late = 1'b1;
        end else if (w_pred_any) begin
          w_pc_nxt   = w_pred_tgt;
          w_pred_use = 1'b1;
        end else begin
          w_pc_nxt = w_seq_pc;
        end
      end
      S_APPLY: begin
        w_pc_nxt = w_redir_tgt;
        w_apply  = 1'b1;
        w_next   = S_REQ;
      end
      default: w_next = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state          <= S_BOOT;
      r_pc             <= '0;
      r_redir_pend     <= 1'b0;
      r_redir_tgt      <= '0;
      r_pred_pend      <= 1'b0;
      r_pred_tgt       <= '0;
      o_req_valid      <= 1'b0;
      o_fetch_valid    <= 1'b0;
      o_fetch_pc       <= '0;
      o_clear_ibuffer  <= 1'b0;
      o_cancel_fetch   <= 1'b0;
      o_redirect_count <= '0;
    end else begin
      r_state         <= w_next;
      r_pc            <= w_pc_nxt;
      o_req_valid     <= (w_next == S_REQ);
      o_fetch_valid   <= (w_next == S_DELIVER);
      o_cancel_fetch  <= (w_next == S_DRAIN);
      o_clear_ibuffer <= (w_next == S_APPLY) | w_clr_late;
      if (w_next == S_DELIVER && r_state != S_DELIVER) o_fetch_pc <= r_pc;
      if (w_apply && o_redirect_count != '1) o_redirect_count <= o_redirect_count + CNT_W'(1);
      if (w_apply) begin
        r_redir_pend <= 1'b0;
        r_pred_pend  <= 1'b0;
      end else if (w_redir_live) begin
        r_redir_pend <= 1'b1;
        r_redir_tgt  <= w_redir_tgt;
        r_pred_pend  <= 1'b0;
      end else if (w_pred_use) begin
        r_pred_pend <= 1'b0;
      end else if (i_predict_valid && !w_pred_block) begin
        r_pred_pend <= 1'b1;
        r_pred_tgt  <= i_predict_target;
      end
    end
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-PC generator for the frontend; successor to the single-width fixed-64B PC controller.
- Owns the fetch PC and issues block-fetch requests to the channel arbiter.
- Hands completed blocks to the ibuffer.
- Arbitrates redirect (backend), interrupt and BPU-predict targets, with explicit cancel/drain of in-flight fetches and alignment-correct sequential advance for any block size.

Parameters:
- ADDR_W, 48, PC width in bits.
- FETCH_BYTES, 64, bytes per fetch block; power of two, at least INST_BYTES.
- INST_BYTES, 4, instruction alignment; power of two.
- INDEX_LO, 3, lowest PC bit driven on req_index.
- INDEX_W, 19, width of req_index; INDEX_LO+INDEX_W must not exceed ADDR_W.
- CNT_W, 16, width of the redirect statistics counter.

Ports:
- clock, input, 1, sole clock.
- reset, input, 1, synchronous, active-high reset.
- boot_addr, input, ADDR_W, PC loaded after reset.
- redirect_valid, input, 1, backend redirect pulse.
- redirect_target, input, ADDR_W, redirect PC.
- interrupt_valid, input, 1, interrupt entry pulse.
- interrupt_addr, input, ADDR_W, interrupt vector.
- predict_valid, input, 1, BPU taken-prediction pulse for the current block.
- predict_target, input, ADDR_W, predicted PC.
- req_valid, output, 1, fetch request to the arbiter.
- req_index, output, INDEX_W, equal to pc[INDEX_LO+INDEX_W-1:INDEX_LO] (combinational from the pc register).
- req_ready, input, 1, arbiter accepts the request this cycle.
- resp_done, input, 1, one-cycle pulse when the accepted fetch completes.
- fetch_valid, output, 1, a block is ready for the ibuffer.
- fetch_pc, output, ADDR_W, PC of the offered block.
- fetch_ack, input, 1, ibuffer takes the block.
- clear_ibuffer, output, 1, one-cycle flush pulse.
- cancel_fetch, output, 1, high while draining a discarded in-flight fetch.
- redirect_count, output, CNT_W, count of applied redirects and interrupts; saturating.

Behaviour:
- All outputs except req_index are registered.
- Reset values: req_valid=0, fetch_valid=0, clear_ibuffer=0, cancel_fetch=0, fetch_pc=0, redirect_count=0, internal pc=0, state=BOOT, pending flags=0.
- Reset asserted mid-operation aborts everything and returns to BOOT. resp_done and fetch_ack arriving during reset are ignored.
- Pending latches:
  - redir_pend/redir_tgt capture redirect_valid or interrupt_valid.
  - When both are valid in the same cycle, redirect wins.
  - A later capture overwrites an earlier one.
  - Targets have their low log2(INST_BYTES) bits forced to 0.
  - pred_pend/pred_tgt capture predict_valid. Any redirect capture clears pred_pend.
  - Effective pending value in any cycle = live input OR latch.
- Sequential next PC = (pc & ~(FETCH_BYTES-1)) + FETCH_BYTES, modulo 2^ADDR_W (wraps to 0). An unaligned redirect target therefore advances to the next block boundary.
- States:
  - BOOT: pc<=boot_addr & ~(INST_BYTES-1). Go to REQ next cycle.
  - REQ: req_valid=1.
    - Redirect pending without req_ready: pc<=target, clear pending, stay in REQ. req_index changes; the arbiter samples it only on req_ready.
    - req_ready with redirect pending: request counts as accepted, go to DRAIN.
    - req_ready otherwise: go to WAIT.
  - WAIT: req_valid=0.
    - resp_done and no redirect: go to DELIVER with fetch_valid=1, fetch_pc=pc.
    - Redirect pending without resp_done: go to DRAIN.
    - Redirect together with resp_done: block discarded, go to APPLY.
  - DRAIN: cancel_fetch=1 until resp_done, then go to APPLY. Redirects during DRAIN update the latch only.
  - DELIVER: fetch_valid held high until fetch_ack.
    - fetch_ack with no redirect: go to NEXT.
    - Redirect pending (with or without ack): fetch_valid drops next cycle, go to APPLY.
  - NEXT: one cycle. Priority is redirect > predict > sequential.
    - Redirect: apply it as in APPLY.
    - Predict: pc<=pred_tgt & ~(INST_BYTES-1), clear pred_pend.
    - Otherwise: pc<=sequential next.
    - Then go to REQ.
  - APPLY: one cycle. pc<=redir_tgt, clear redir_pend and pred_pend, clear_ibuffer=1 for exactly this cycle, redirect_count+=1 (saturates at all-ones). Then go to REQ.
- Sustained latency: REQ→WAIT needs ≥1 cycle after req_ready. From fetch_ack to the next req_valid is 2 cycles (NEXT, REQ).
- A predict arriving while a redirect is pending or in progress is dropped.
- resp_done outside WAIT and DRAIN is ignored. fetch_ack outside DELIVER is ignored.

Test Plan:
- Boot: reset 2 cycles with boot_addr=0x1000. Required: req_valid=1 in cycle 2 after reset deassert, req_index=0x200; after req_ready and resp_done, fetch_valid=1 with fetch_pc=0x1000.
- Sequential advance and wrap: 3 acked blocks from 0x1000 give fetch_pc 0x1040 then 0x1080. With pc=0xFFFF_FFFF_FFC0 the next fetch_pc is 0x0.
- Unaligned redirect: redirect_target=0x2004 while in DELIVER. Required: fetch_valid drops, clear_ibuffer pulses 1 cycle, next fetch_pc=0x2004, following fetch_pc=0x2040, redirect_count=1.
- Cancel/drain: redirect to 0x3000 while in WAIT. Required: cancel_fetch=1 until resp_done, no fetch_valid for the old block, next req_index=0x600.
- Priority: redirect 0x4000 and interrupt 0x8000 in the same cycle, plus a predict 0x5000 just before. Required: next fetch_pc=0x4000 and the predict is dropped. A lone predict 0x5000 during DELIVER gives next fetch_pc=0x5000.
- Reset mid-fetch: assert reset in WAIT, then pulse resp_done. Required: all outputs 0 and the FSM restarts from boot_addr; the stale resp_done is ignored.
